// File: rtl/branch_redirect_ctrl.sv
// PC redirect sequencer for the 5-stage MIPS pipeline: resolves jr/j/jal/branches
// from EX, holds the redirect across stalls, issues flushes and keeps statistics.
module branch_redirect_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcen,
  input  logic             ex_valid,
  input  logic [5:0]       ex_op,
  input  logic [5:0]       ex_funct,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_aluout,
  input  logic [25:0]      ex_label,
  input  logic [31:0]      ex_rfd1,
  input  logic             cnt_clr,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] uncondsum,
  output logic [CNT_W-1:0] condsum,
  output logic [CNT_W-1:0] condsuccsum
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SHADOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_e            state_q, state_d;
  logic              redirect_q, redirect_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  unc_q, unc_d;
  logic [CNT_W-1:0]  cond_q, cond_d;
  logic [CNT_W-1:0]  succ_q, succ_d;

  logic              is_jr_s, is_j_s, is_cond_s, cond_taken_s;
  logic              capture_s, take_s;
  logic [31:0]       pc4_s, br_off_s, target_s;

  assign is_jr_s   = (ex_op == 6'h00) && (ex_funct == 6'h08);
  assign is_j_s    = (ex_op == 6'h02) || (ex_op == 6'h03);
  assign is_cond_s = (ex_op == 6'h04) || (ex_op == 6'h05) || (ex_op == 6'h01);

  assign pc4_s    = ex_pc + 32'd4;
  assign br_off_s = {{14{ex_label[15]}}, ex_label[15:0], 2'b00};

  // Branch condition and redirect target selection
  always_comb begin
    cond_taken_s = 1'b0;
    target_s     = pc4_s + br_off_s;
    case (ex_op)
      6'h04:   cond_taken_s = (ex_aluout == 32'h0000_0000);
      6'h05:   cond_taken_s = (ex_aluout != 32'h0000_0000);
      6'h01:   cond_taken_s = (ex_aluout == 32'h0000_0001);
      default: cond_taken_s = 1'b0;
    endcase
    if (is_jr_s) begin
      target_s = ex_rfd1;
    end else if (is_j_s) begin
      target_s = {pc4_s[31:28], ex_label, 2'b00};
    end else begin
      target_s = pc4_s + br_off_s;
    end
  end

  // Only IDLE accepts events; PENDING and SHADOW see stale or wrong-path EX slots.
  assign capture_s = (state_q == S_IDLE) && ex_valid && (is_jr_s || is_j_s || is_cond_s);
  assign take_s    = capture_s && (is_jr_s || is_j_s || (is_cond_s && cond_taken_s));

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (take_s) begin
          state_d       = S_PENDING;
          redirect_d    = 1'b1;
          redirect_pc_d = target_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        if (pcen) begin
          state_d    = S_SHADOW;
          redirect_d = 1'b0;
        end else begin
          state_d    = S_PENDING;
          redirect_d = 1'b1;
        end
      end
      S_SHADOW: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Statistics counters; clear beats a same-cycle increment
  always_comb begin
    unc_d  = unc_q;
    cond_d = cond_q;
    succ_d = succ_q;
    if (cnt_clr) begin
      unc_d  = CNT_ZERO;
      cond_d = CNT_ZERO;
      succ_d = CNT_ZERO;
    end else if (capture_s) begin
      if (is_jr_s || is_j_s) begin
        unc_d = unc_q + CNT_ONE;
      end else begin
        cond_d = cond_q + CNT_ONE;
        if (cond_taken_s) begin
          succ_d = succ_q + CNT_ONE;
        end else begin
          succ_d = succ_q;
        end
      end
    end else begin
      unc_d = unc_q;
    end
  end

  // State, output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= RESET_PC;
      unc_q         <= CNT_ZERO;
      cond_q        <= CNT_ZERO;
      succ_q        <= CNT_ZERO;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      unc_q         <= unc_d;
      cond_q        <= cond_d;
      succ_q        <= succ_d;
    end
  end

  assign redirect    = redirect_q;
  assign flush_ifid  = redirect_q;
  assign flush_idex  = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign uncondsum   = unc_q;
  assign condsum     = cond_q;
  assign condsuccsum = succ_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: expected targets are queued at capture
// and popped when redirect rises; counters and flushes are checked at fixed points.
module tb_branch_redirect_ctrl;

  // Narrow counters so the wrap can be reached with a short run of jumps.
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, pcen, ex_valid, cnt_clr;
  logic [5:0]       ex_op, ex_funct;
  logic [31:0]      ex_pc, ex_aluout, ex_rfd1;
  logic [25:0]      ex_label;
  logic             redirect, flush_ifid, flush_idex;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] uncondsum, condsum, condsuccsum;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [31:0]      exp_q[$];
  logic             redirect_prev = 1'b0;
  logic [CNT_W-1:0] exp_unc;

  branch_redirect_ctrl #(.CNT_W(CNT_W), .RESET_PC(32'h00003000)) dut (
    .clk(clk), .rst(rst), .pcen(pcen), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_funct(ex_funct), .ex_pc(ex_pc), .ex_aluout(ex_aluout), .ex_label(ex_label),
    .ex_rfd1(ex_rfd1), .cnt_clr(cnt_clr), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .uncondsum(uncondsum),
    .condsum(condsum), .condsuccsum(condsuccsum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [25:0] label, input logic [31:0] rfd1);
    ex_valid  = 1'b1;
    ex_op     = op;
    ex_funct  = funct;
    ex_pc     = pc;
    ex_aluout = alu;
    ex_label  = label;
    ex_rfd1   = rfd1;
  endtask

  // Pop the expected target on each new redirect
  always @(negedge clk) begin
    if (redirect && !redirect_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_redirect", 32'd1, 32'd0);
      end else begin
        chk("redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end
    redirect_prev = redirect;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pcen = 1'b1; ex_valid = 1'b0; cnt_clr = 1'b0;
    ex_op = 6'h00; ex_funct = 6'h00; ex_pc = 32'h0; ex_aluout = 32'h0;
    ex_label = 26'h0; ex_rfd1 = 32'h0;
    step(); step();
    rst = 1'b0;
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_flush_ifid", {31'd0, flush_ifid}, 32'd0);
    chk("rst_flush_idex", {31'd0, flush_idex}, 32'd0);
    chk("rst_pc", redirect_pc, 32'h00003000);
    chk("rst_unc", {24'd0, uncondsum}, 32'd0);
    chk("rst_cond", {24'd0, condsum}, 32'd0);
    chk("rst_succ", {24'd0, condsuccsum}, 32'd0);

    // beq taken, backward offset
    drive(6'h04, 6'h00, 32'h00003010, 32'h0, 26'h000FFFE, 32'h0);
    exp_q.push_back(32'h0000300C);
    step();
    ex_valid = 1'b0;
    chk("beq_redirect", {31'd0, redirect}, 32'd1);
    chk("beq_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    chk("beq_flush_idex", {31'd0, flush_idex}, 32'd1);
    chk("beq_cond", {24'd0, condsum}, 32'd1);
    chk("beq_succ", {24'd0, condsuccsum}, 32'd1);
    step();
    chk("beq_width", {31'd0, redirect}, 32'd0);
    chk("beq_flush_off", {31'd0, flush_ifid}, 32'd0);
    drive(6'h05, 6'h00, 32'h00003100, 32'h1, 26'h0000010, 32'h0);
    step();
    ex_valid = 1'b0;
    chk("shadow_redirect", {31'd0, redirect}, 32'd0);
    chk("shadow_cond", {24'd0, condsum}, 32'd1);
    chk("shadow_succ", {24'd0, condsuccsum}, 32'd1);

    // bne not taken
    drive(6'h05, 6'h00, 32'h00003200, 32'h0, 26'h0000010, 32'h0);
    step();
    ex_valid = 1'b0;
    chk("bne_redirect", {31'd0, redirect}, 32'd0);
    chk("bne_cond", {24'd0, condsum}, 32'd2);
    chk("bne_succ", {24'd0, condsuccsum}, 32'd1);

    // op 01 not taken when aluout is not exactly 1
    drive(6'h01, 6'h00, 32'h00003300, 32'h2, 26'h0000010, 32'h0);
    step();
    ex_valid = 1'b0;
    chk("op01_nt_redirect", {31'd0, redirect}, 32'd0);
    chk("op01_nt_succ", {24'd0, condsuccsum}, 32'd1);

    // jr with a three-cycle stall; EX held stable throughout
    drive(6'h00, 6'h08, 32'h00003400, 32'h0, 26'h0, 32'h00003400);
    exp_q.push_back(32'h00003400);
    step();
    pcen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("jr_hold", {31'd0, redirect}, 32'd1);
      chk("jr_hold_pc", redirect_pc, 32'h00003400);
      step();
    end
    chk("jr_hold4", {31'd0, redirect}, 32'd1);
    chk("jr_hold4_flush", {31'd0, flush_idex}, 32'd1);
    pcen = 1'b1;
    step();
    ex_valid = 1'b0;
    chk("jr_released", {31'd0, redirect}, 32'd0);
    chk("jr_unc_once", {24'd0, uncondsum}, 32'd1);
    step();

    // jal across a pc4 wrap: pc4 becomes 0
    drive(6'h03, 6'h00, 32'hFFFFFFFC, 32'h0, 26'h0000400, 32'h0);
    exp_q.push_back(32'h00001000);
    step();
    ex_valid = 1'b0;
    step(); step();
    chk("jal_unc", {24'd0, uncondsum}, 32'd2);
    exp_unc = 8'd2;

    // run of jumps up to the counter limit
    while (exp_unc != 8'hFF) begin
      drive(6'h02, 6'h00, 32'h00000000, 32'h0, 26'h0000001, 32'h0);
      exp_q.push_back(32'h00000004);
      step();
      ex_valid = 1'b0;
      exp_unc  = exp_unc + 8'd1;
      step(); step();
    end
    chk("unc_preload", {24'd0, uncondsum}, 32'h000000FF);

    // j that wraps the counter
    drive(6'h02, 6'h00, 32'h10000000, 32'h0, 26'h0000C00, 32'h0);
    exp_q.push_back(32'h10003000);
    step();
    ex_valid = 1'b0;
    chk("j_wrap_unc", {24'd0, uncondsum}, 32'd0);
    chk("j_redirect", {31'd0, redirect}, 32'd1);
    step(); step();

    // clear concurrent with a taken op 01; redirect still happens, then stall
    drive(6'h01, 6'h00, 32'h00003000, 32'h1, 26'h0000004, 32'h0);
    cnt_clr = 1'b1;
    exp_q.push_back(32'h00003014);
    step();
    ex_valid = 1'b0;
    cnt_clr  = 1'b0;
    pcen     = 1'b0;
    chk("clr_unc", {24'd0, uncondsum}, 32'd0);
    chk("clr_cond", {24'd0, condsum}, 32'd0);
    chk("clr_succ", {24'd0, condsuccsum}, 32'd0);
    chk("clr_redirect", {31'd0, redirect}, 32'd1);
    step();
    chk("clr_pending", {31'd0, redirect}, 32'd1);

    // reset during PENDING drops the redirect
    rst = 1'b1;
    step();
    rst  = 1'b0;
    pcen = 1'b1;
    chk("rst_pend_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_pend_flush", {31'd0, flush_ifid}, 32'd0);
    chk("rst_pend_pc", redirect_pc, 32'h00003000);
    step();
    chk("rst_pend_stays", {31'd0, redirect}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
